conv_out_writer: RTL and testbench
==================================

# conv_out_writer

Write-side companion to the input-window address counter. It accepts the convolution engine's result stream over a valid/ready handshake and saturates each accumulator value to the output data width. It generates row/column write addresses for the output feature-map RAM, writing one pixel per accepted beat in raster order. It signals `done` after the last pixel of the frame is written.

## Interface
- `OUT_COLS`, default 8: output feature-map width (columns per row).
- `OUT_ROWS`, default 6: output feature-map height.
- `ACC_W`, default 20: signed accumulator width from the conv engine.
- `DATA_W`, default 8: signed stored pixel width.
- `ADDR_W`, default 6: RAM address width; must satisfy 2^ADDR_W ≥ OUT_COLS*OUT_ROWS.
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset. Assertion (low) clears all state immediately.
- `start`, input, 1: begins a frame; sampled only in IDLE.
- `in_valid`, input, 1: result beat available.
- `in_data`, input, ACC_W: signed accumulator value.
- `in_ready`, output, 1: writer accepts the beat this cycle.
- `mem_we`, output, 1: RAM write strobe.
- `mem_addr`, output, ADDR_W: RAM write address.
- `mem_wdata`, output, DATA_W: saturated pixel.
- `row`, output, 7: current row index of the next beat to accept.
- `col`, output, 7: current column index of the next beat to accept.
- `busy`, output, 1: high in RUN and FLUSH.
- `done`, output, 1: one-cycle pulse at frame completion.

## Operation
- FSM states: IDLE, RUN, FLUSH.
  - IDLE → RUN when `start` is high. On that transition, `row`, `col` and the address register are cleared to 0.
  - RUN → FLUSH when the beat at `row`=OUT_ROWS-1, `col`=OUT_COLS-1 is accepted.
  - FLUSH → IDLE after one cycle.
  - `start` is ignored outside IDLE.
- Handshake: `in_ready` = (state == RUN). A beat is accepted when `in_valid` && `in_ready` are both high. `in_data` is not sampled otherwise. `in_valid` may drop between beats; a gap stalls the counters without any penalty.
- Counters advance per accepted beat:
  - `col` increments.
  - At `col`=OUT_COLS-1, `col` wraps to 0 and `row` increments.
  - `mem_addr` = row*OUT_COLS + col. It is kept as a separate incrementing register, not a multiplier, and runs 0 … OUT_COLS*OUT_ROWS-1 with no gaps.
  - After the final beat, `row`/`col` hold their last values until the next `start`.
- Saturation is signed:
  - `in_data` > 2^(DATA_W-1)-1 → 127 (for DATA_W=8).
  - `in_data` < -2^(DATA_W-1) → -128.
  - Otherwise, the low DATA_W bits are passed through.
- Reset values, all outputs: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `row`=0, `col`=0, `busy`=0, `done`=0; state=IDLE.
- Reset asserted mid-frame: the frame is abandoned and no partial `done` is produced. A write in flight is dropped, i.e. `mem_we` goes low immediately.

## Timing
- Write latency is exactly 1 cycle. A beat accepted at edge N produces `mem_we`=1 with its address and saturated data during the cycle after edge N. `mem_we` is low in any cycle that follows a non-accept cycle.
- `done` is high during the same cycle as the last `mem_we` (FLUSH state), then low.
- `busy` is low in the cycle `done` is high? No: `busy` is high through FLUSH and falls together with the IDLE return.
- Back-to-back frames: `start` sampled in the first IDLE cycle after FLUSH. The minimum frame period is OUT_COLS*OUT_ROWS + 2 cycles.
- Throughput: 1 beat per cycle sustained in RUN.

## Structure
- Shared package `cnn_pkg`:
  - FSM state enum (IDLE/RUN/FLUSH).
  - Default feature-map dimensions.
  - `sat_signed` function (ACC_W → DATA_W). The input-side counter and pooling blocks reuse the same dimensions.
- One natural sub-module: `sat_clip` (combinational signed saturator, parameterised ACC_W/DATA_W). Instantiate it before the output register.

## Test plan
- Full frame: `start`, then 48 consecutive beats with `in_data`=k → `mem_addr` 0..47 in order, `mem_wdata`=k, one `done` pulse coincident with addr 47, `busy` falls the next cycle.
- Saturation: beats of 300, -500, 127, -128, -1 → `mem_wdata` = 127, -128, 127, -128, -1.
- Stalls: random `in_valid` gaps (30% idle) → same address/data sequence as the full-frame case, no `mem_we` during gaps, and `row`/`col` frozen.
- Wrap: after beat 7 is accepted, `row`=1 and `col`=0; after beat 47, `row`=5 and `col`=7 are held.
- `start` held high through the whole frame → no restart; exactly one frame of 48 writes.
- Reset low at beat 20 → all outputs 0 immediately and no `done`. A new `start` then writes from addr 0 again.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types and defaults for the CNN datapath: FSM states, feature-map
// dimensions, and the signed saturation helper used by the writer.
package cnn_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int OUT_COLS_DEF = 8;
    localparam int OUT_ROWS_DEF = 6;
    localparam int ACC_W_DEF    = 20;
    localparam int DATA_W_DEF   = 8;

    // Clamp a sign-extended accumulator into the signed range of data_w bits.
    function automatic longint sat_signed(input longint value, input int data_w);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (data_w - 1)) - longint'(1);
        lo = -hi - longint'(1);
        if (value > hi) return hi;
        if (value < lo) return lo;
        return value;
    endfunction

endpackage

// File: rtl/sat_clip.sv
// Combinational signed saturator: narrows an ACC_W accumulator to DATA_W,
// clipping to the most positive / most negative representable value.
module sat_clip
    import cnn_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic signed [ACC_W-1:0]  in_data,
    output logic        [DATA_W-1:0] out_data
);

    // The signed cast sign-extends; in-range values keep their low DATA_W bits.
    always_comb out_data = DATA_W'(sat_signed(longint'(in_data), DATA_W));

endmodule

// File: rtl/conv_out_writer.sv
// Output-side writer: takes conv results over valid/ready, saturates them and
// writes one pixel per accepted beat to the output feature-map RAM in raster order.
module conv_out_writer
    import cnn_pkg::*;
#(
    parameter int OUT_COLS = OUT_COLS_DEF,
    parameter int OUT_ROWS = OUT_ROWS_DEF,
    parameter int ACC_W    = ACC_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic signed [ACC_W-1:0] in_data,
    output logic                    in_ready,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic [6:0]              row,
    output logic [6:0]              col,
    output logic                    busy,
    output logic                    done
);

    localparam logic [6:0] COL_LAST = 7'(OUT_COLS - 1);
    localparam logic [6:0] ROW_LAST = 7'(OUT_ROWS - 1);

    state_t            state;
    state_t            state_nx;
    logic              accept;
    logic              last_beat;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] sat_data;

    assign accept    = (state == RUN) && in_valid;
    assign last_beat = (row == ROW_LAST) && (col == COL_LAST);

    sat_clip #(
        .ACC_W  (ACC_W),
        .DATA_W (DATA_W)
    ) u_sat_clip (
        .in_data  (in_data),
        .out_data (sat_data)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // NOTE: default assignment first so no path through the case infers a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (accept && last_beat) state_nx = FLUSH;
            FLUSH:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FLUSH is the cycle carrying the final write, so done lines up with it.
    always_comb begin
        in_ready = (state == RUN);
        busy     = (state != IDLE);
        done     = (state == FLUSH);
    end

    // wr_addr is a running counter so no row*OUT_COLS multiplier is needed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            row       <= '0;
            col       <= '0;
            wr_addr   <= '0;
        end else begin
            mem_we <= accept;
            if (state == IDLE && start) begin
                row     <= '0;
                col     <= '0;
                wr_addr <= '0;
            end else if (accept) begin
                mem_addr  <= wr_addr;
                mem_wdata <= sat_data;
                // The last beat leaves row/col parked on the final pixel.
                if (!last_beat) begin
                    wr_addr <= wr_addr + ADDR_W'(1);
                    if (col == COL_LAST) begin
                        col <= '0;
                        row <= row + 7'd1;
                    end else begin
                        col <= col + 7'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_out_writer.sv
// Self-checking bench for conv_out_writer: per-cycle scoreboard of writes,
// handshake, counters and frame control against a plain arithmetic model.
module tb_conv_out_writer;

    localparam int COLS = 8;
    localparam int ROWS = 6;
    localparam int NPIX = COLS * ROWS;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               in_valid = 1'b0;
    logic signed [19:0] in_data = '0;
    logic               in_ready;
    logic               mem_we;
    logic [5:0]         mem_addr;
    logic [7:0]         mem_wdata;
    logic [6:0]         row;
    logic [6:0]         col;
    logic               busy;
    logic               done;

    int n_cmp = 0;
    int n_err = 0;

    int         vals[NPIX];
    logic [7:0] expd[NPIX];

    typedef struct {
        int         din;
        logic [7:0] dout;
    } sat_vec_t;

    sat_vec_t tbl[12];

    conv_out_writer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .row       (row),
        .col       (col),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_sat(input int v);
        if (v > 127)  return 8'h7f;
        if (v < -128) return 8'h80;
        return v[7:0];
    endfunction

    task automatic fill_ramp();
        for (int i = 0; i < NPIX; i++) begin
            vals[i] = i;
            expd[i] = ref_sat(i);
        end
    endtask

    task automatic fill_random();
        int v;
        for (int i = 0; i < NPIX; i++) begin
            if ($urandom_range(1) == 1) v = int'($urandom_range(600)) - 300;
            else                        v = int'($urandom_range(1048575)) - 524288;
            vals[i] = v;
            expd[i] = ref_sat(v);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".in_ready"},  in_ready,  0);
        check({tag, ".mem_we"},    mem_we,    0);
        check({tag, ".mem_addr"},  mem_addr,  0);
        check({tag, ".mem_wdata"}, mem_wdata, 0);
        check({tag, ".row"},       row,       0);
        check({tag, ".col"},       col,       0);
        check({tag, ".busy"},      busy,      0);
        check({tag, ".done"},      done,      0);
    endtask

    task automatic do_abort(input string tag);
        rst = 1'b0;
        #1;
        check_all_zero({tag, ".abort"});
        in_valid = 1'b0;
        start    = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check({tag, ".abort_done"}, done, 0);
            check({tag, ".abort_we"},   mem_we, 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Entered and left just after a rising edge with the DUT idle.
    task automatic run_frame(input string tag, input int gap_pct, input bit hold_start,
                             input int abort_at);
        int k = 0;
        int cyc = 0;
        int nwr = 0;
        int ndone = 0;
        int pend_addr = 0;
        int rc;
        bit pend = 0;
        bit flush_seen = 0;
        bit exp_ready;
        bit exp_done;
        bit exp_busy;
        start    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, ".idle_busy"}, busy, 0);
        check({tag, ".idle_rdy"},  in_ready, 0);
        @(posedge clk);
        #1;
        if (!hold_start) start = 1'b0;
        while (1) begin
            if (cyc >= 600) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s.timeout: got %0d beats, want %0d", tag, k, NPIX);
                break;
            end
            cyc++;
            if (k < NPIX) in_valid = ($urandom_range(99) >= 32'(gap_pct));
            else          in_valid = 1'($urandom_range(1));
            in_data = 20'(vals[(k < NPIX) ? k : 0]);
            @(negedge clk);
            exp_ready = (k < NPIX);
            exp_done  = pend && (pend_addr == NPIX - 1);
            exp_busy  = exp_ready || exp_done;
            rc        = (k < NPIX) ? k : NPIX - 1;
            if (mem_we === 1'b1) nwr++;
            if (done === 1'b1)   ndone++;
            check({tag, ".we"}, mem_we, 32'(pend));
            if (pend) begin
                check({tag, ".addr"}, mem_addr, pend_addr);
                check({tag, ".data"}, mem_wdata, expd[pend_addr]);
            end
            check({tag, ".done"}, done,     32'(exp_done));
            check({tag, ".busy"}, busy,     32'(exp_busy));
            check({tag, ".rdy"},  in_ready, 32'(exp_ready));
            check({tag, ".row"},  row,      rc / COLS);
            check({tag, ".col"},  col,      rc % COLS);
            if (exp_done) flush_seen = 1;
            if (abort_at >= 0 && k == abort_at) begin
                do_abort(tag);
                return;
            end
            if (k == NPIX && !pend) break;
            pend = in_valid && exp_ready;
            if (pend) begin
                pend_addr = k;
                k++;
            end
            @(posedge clk);
            #1;
            if (flush_seen) start = 1'b0;
        end
        check({tag, ".n_writes"}, nwr,   NPIX);
        check({tag, ".n_done"},   ndone, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, ".no_restart_we"},   mem_we, 0);
        check({tag, ".no_restart_busy"}, busy,   0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = '{300,     8'h7f};
        tbl[1]  = '{-500,    8'h80};
        tbl[2]  = '{127,     8'h7f};
        tbl[3]  = '{-128,    8'h80};
        tbl[4]  = '{-1,      8'hff};
        tbl[5]  = '{128,     8'h7f};
        tbl[6]  = '{-129,    8'h80};
        tbl[7]  = '{0,       8'h00};
        tbl[8]  = '{524287,  8'h7f};
        tbl[9]  = '{-524288, 8'h80};
        tbl[10] = '{5,       8'h05};
        tbl[11] = '{-7,      8'hf9};

        // Held in reset: every output low.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("post_reset");
        @(posedge clk);
        #1;

        fill_ramp();
        run_frame("full", 0, 1'b0, -1);

        fill_random();
        for (int i = 0; i < 12; i++) begin
            vals[i] = tbl[i].din;
            expd[i] = tbl[i].dout;
        end
        run_frame("sat_tbl", 0, 1'b0, -1);

        fill_random();
        run_frame("stall_a", 30, 1'b0, -1);
        fill_random();
        run_frame("stall_b", 30, 1'b0, -1);

        fill_ramp();
        run_frame("hold_start", 0, 1'b1, -1);

        fill_ramp();
        run_frame("abort", 0, 1'b0, 20);
        run_frame("after_abort", 10, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
